// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit and its prefetch buffer.
//
// Contents:
//   XLEN / ILEN       address and instruction widths (32 bits each)
//   ENTRY_W           width of one prefetch buffer entry {pc, instr}
//   DEFAULT_RESET_PC  default first fetch address after reset
//   fetch_state_t     fetch FSM state encoding
//   fetch_entry_t     packed view of one buffer entry
//   next_word()       sequential fetch address helper (wraps at 32 bits)
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int ENTRY_W = XLEN + ILEN;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_BYTES       = 32'd4;

    // IDLE  : buffer full, no request pending
    // REQ   : mem_req asserted, waiting for a grant
    // WAIT  : one granted request outstanding, waiting for its data
    // FLUSH : a redirected-away request is outstanding; its data is dropped
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Sequential next fetch address; natural 32-bit wrap takes
    // 32'hFFFFFFFC back to 32'h00000000.
    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] pc);
        return pc + WORD_BYTES;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Two-entry FIFO holding fetched {pc, instruction} pairs in program order.
// The head entry is driven straight from storage registers, so nothing
// on the write side can reach dout combinationally.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push         write din at the tail (accepted when not full, or when a
//                pop frees a slot in the same cycle)
//   pop          drop the head entry; ignored when empty
//   flush        empty the FIFO; overrides push and pop
//   din          entry to write, {pc, instr}
//   dout         head entry, {pc, instr}
//   count        current occupancy, 0..2
// ---------------------------------------------------------------------------
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic [1:0]         count
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [ENTRY_W-1:0] slots [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic               do_push;
    logic               do_pop;

    // A pop on an empty FIFO must not move the read pointer, and a push
    // into a full FIFO is only legal when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != FULL_COUNT) || do_pop);
    end

    // Storage, pointers and occupancy. Flush resets the pointers but leaves
    // the slot contents alone; they are meaningless once count is zero.
    // Push and pop together leave the occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots[0] <= '0;
            slots[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else if (flush) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= din;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout = slots[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: issues one word-aligned request at a time to
// instruction memory, collects the returned words into a 2-entry prefetch
// buffer and presents the oldest one to decode. A redirect empties the
// buffer, restarts fetching at the new address and discards any data still
// owed by memory for the abandoned request.
//
// Parameters:
//   RESET_PC    first fetch address after reset (bits [1:0] must be zero)
//   BUF_DEPTH   prefetch buffer entries (only 2 is supported)
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   mem_req      fetch request, high only in REQ
//   mem_addr     fetch address (current fetch_pc)
//   mem_gnt      memory accepted the request this cycle
//   mem_valid    memory returns read data this cycle
//   mem_rdata    returned instruction word
//   redirect     single-cycle branch/exception redirect
//   redirect_pc  new fetch address, low two bits ignored
//   ir           instruction at the buffer head
//   ir_pc        fetch address of ir
//   ir_valid     ir/ir_pc hold a valid instruction
//   ir_ack       decode consumes ir this cycle (ignored while ir_valid=0)
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_valid,
    input  logic [ILEN-1:0] mem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [ILEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc,
    output logic            ir_valid,
    input  logic            ir_ack
);

    localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

    fetch_state_t    state;
    fetch_state_t    next_state;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] grant_pc;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_bits;

    logic            granted;
    logic            buf_push;
    logic            buf_pop;
    logic [1:0]      occupancy;
    logic [2:0]      occ_after;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Handshake qualifiers. Data is only ever accepted in WAIT, which is
    // what makes mem_valid in any other state (including straight after
    // reset) harmless. A redirect kills the push for data arriving in the
    // same cycle; the buffer flush also overrides any pop.
    always_comb begin
        granted    = (state == ST_REQ) && mem_gnt;
        buf_push   = (state == ST_WAIT) && mem_valid && !redirect;
        buf_pop    = ir_ack && ir_valid;
        occ_after  = {1'b0, occupancy} + {2'b0, buf_push} - {2'b0, buf_pop};
        push_entry = '{pc: grant_pc, instr: mem_rdata};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Only one granted request is ever in flight, so a
    // redirect after the grant cannot simply restart: it has to go through
    // FLUSH to soak up the data memory still owes. IDLE re-checks the
    // registered occupancy, so a pop there restarts fetching one cycle
    // later; WAIT instead looks at the occupancy after this cycle's push
    // and pop so a steady stream never stalls.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (redirect || (occupancy < BUF_FULL)) begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    next_state = redirect ? ST_FLUSH : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    next_state = mem_valid ? ST_REQ : ST_FLUSH;
                end else if (mem_valid) begin
                    next_state = (occ_after < {1'b0, BUF_FULL}) ? ST_REQ : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (mem_valid) begin
                    next_state = ST_REQ;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Memory-side outputs. The address is held in fetch_pc, which only
    // moves on a grant or a redirect, so an ungranted request stays stable.
    always_comb begin
        mem_req  = (state == ST_REQ);
        mem_addr = fetch_pc;
    end

    // Fetch address tracking. grant_pc remembers which address the
    // outstanding request was for, since fetch_pc has already advanced by
    // the time its data comes back. A redirect always wins over the
    // post-grant increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            grant_pc <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_target;
            end else if (granted) begin
                fetch_pc <= next_word(fetch_pc);
            end
            if (granted) begin
                grant_pc <= fetch_pc;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head),
        .count (occupancy)
    );

    // Decode-side outputs come straight from the buffer head registers.
    assign ir       = head.instr;
    assign ir_pc    = head.pc;
    assign ir_valid = (occupancy != 2'd0);

endmodule
